qspi_target: RTL and testbench

// - Mode-3 SPI/DPI/QPI target that answers the FX2 QSPI bridge. It is the far end of the bridge's bus and is used as a flash stand-in on the bench and on the board.
// - SPI_CS, SPI_CLK and the IO lanes are oversampled on FX_IFCLK.
// - Received bytes go out on a byte strobe. Transmit bytes come in through a valid/ready holding register.

---
 rtl/qspi_target.sv | 233 +++++++++++++++++++++++
 tb/tb_qspi_target.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_target.sv
// rtl/qspi_target.sv - mode-3 SPI/DPI/QPI target for the FX2 QSPI bridge (option macro: QSPI_TARGET_ECHO_EN)
module qspi_target #(
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_W     = 12
) (
  input  logic               FX_IFCLK,
  input  logic               RST,
  input  logic               SPI_CS,
  input  logic               SPI_CLK,
  input  logic [3:0]         io_in,
  output logic [3:0]         io_out,
  output logic [3:0]         io_oe,
  input  logic [1:0]         cfg_mode,
  input  logic               cfg_dir,
  output logic [7:0]         rx_data,
  output logic               rx_valid,
  input  logic [7:0]         tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic               tx_underrun,
  output logic [COUNT_W-1:0] byte_count,
  output logic               busy
);

  typedef enum logic [1:0] {S_WAIT_HI, S_IDLE, S_RX, S_TX} state_t;

  localparam logic [1:0] M_SPI = 2'b00;
  localparam logic [1:0] M_DPI = 2'b01;
  localparam logic [1:0] M_QPI = 2'b10;

  logic [SYNC_STAGES-1:0] cs_sr;
  logic [SYNC_STAGES-1:0] sck_sr;
  logic [3:0]             io_sr [SYNC_STAGES];
  logic                   cs_s;
  logic                   sck_s;
  logic [3:0]             io_s;
  logic                   cs_prev;
  logic                   sck_prev;
  logic                   cs_fall;
  logic                   sck_rise;
  logic                   sck_fall;

  state_t                 state_q;
  state_t                 state_d;
  logic [1:0]             mode_q;
  logic [2:0]             edge_cnt;
  logic                   last_edge;
  logic [7:0]             rx_shift;
  logic [7:0]             rx_next;
  logic [7:0]             tx_shift;
  logic [7:0]             fill_byte;
  logic [7:0]             load_byte;
  logic [7:0]             hold_data;
  logic                   hold_full;
  logic                   tx_load;
  logic                   tx_write;

  assign cs_s  = cs_sr[SYNC_STAGES-1];
  assign sck_s = sck_sr[SYNC_STAGES-1];
  assign io_s  = io_sr[SYNC_STAGES-1];

  assign cs_fall  = cs_prev & ~cs_s;
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;

  // Next MSB-first slice placed on the lanes that the latched mode drives.
  function automatic logic [3:0] lane_bits(input logic [1:0] m, input logic [7:0] b);
    case (m)
      M_DPI:   return {2'b00, b[7:6]};
      M_QPI:   return b[7:4];
      default: return {2'b00, b[7], 1'b0};
    endcase
  endfunction

  // Shift register advance by one edge's worth of bits.
  function automatic logic [7:0] shift_out(input logic [1:0] m, input logic [7:0] b);
    case (m)
      M_DPI:   return {b[5:0], 2'b00};
      M_QPI:   return {b[3:0], 4'b0000};
      default: return {b[6:0], 1'b0};
    endcase
  endfunction

  // Synchronise the bus pins; CS resets low so a reset mid-transaction waits for a genuine CS high.
  always_ff @(posedge FX_IFCLK) begin
    if (RST) begin
      cs_sr    <= '0;
      sck_sr   <= '1;
      cs_prev  <= 1'b0;
      sck_prev <= 1'b1;
      for (int i = 0; i < SYNC_STAGES; i++) io_sr[i] <= '0;
    end else begin
      cs_sr    <= {cs_sr[SYNC_STAGES-2:0], SPI_CS};
      sck_sr   <= {sck_sr[SYNC_STAGES-2:0], SPI_CLK};
      io_sr[0] <= io_in;
      for (int i = 1; i < SYNC_STAGES; i++) io_sr[i] <= io_sr[i-1];
      cs_prev  <= cs_s;
      sck_prev <= sck_s;
    end
  end

  // Receive shift value after this edge's lanes are appended.
  always_comb begin
    rx_next = {rx_shift[6:0], io_s[0]};
    case (mode_q)
      M_DPI:   rx_next = {rx_shift[5:0], io_s[1:0]};
      M_QPI:   rx_next = {rx_shift[3:0], io_s};
      default: rx_next = {rx_shift[6:0], io_s[0]};
    endcase
  end

  // Last rising edge of a byte: 8, 4 or 2 edges per byte.
  always_comb begin
    last_edge = (edge_cnt == 3'd7);
    case (mode_q)
      M_DPI:   last_edge = (edge_cnt == 3'd3);
      M_QPI:   last_edge = (edge_cnt == 3'd1);
      default: last_edge = (edge_cnt == 3'd7);
    endcase
  end

`ifdef QSPI_TARGET_ECHO_EN
  assign fill_byte = rx_data;
`else
  assign fill_byte = 8'hFF;
`endif

  assign tx_ready  = ~hold_full;
  assign tx_write  = tx_valid & ~hold_full;
  assign tx_load   = (state_q == S_TX) & ~cs_s & sck_fall & (edge_cnt == 3'd0);
  assign load_byte = hold_full ? hold_data : fill_byte;

  // FSM state register.
  always_ff @(posedge FX_IFCLK) begin
    if (RST) state_q <= S_WAIT_HI;
    else     state_q <= state_d;
  end

  // Next state, lane enables and busy.
  always_comb begin
    state_d = state_q;
    io_oe   = 4'b0000;
    busy    = 1'b0;
    case (state_q)
      S_WAIT_HI: if (cs_s) state_d = S_IDLE;
      S_IDLE:    if (cs_fall) state_d = cfg_dir ? S_TX : S_RX;
      S_RX: begin
        busy = 1'b1;
        if (cs_s) state_d = S_IDLE;
      end
      S_TX: begin
        busy = 1'b1;
        if (cs_s) begin
          state_d = S_IDLE;
        end else begin
          case (mode_q)
            M_DPI:   io_oe = 4'b0011;
            M_QPI:   io_oe = 4'b1111;
            default: io_oe = 4'b0010;
          endcase
        end
      end
      default:   state_d = S_WAIT_HI;
    endcase
  end

  // Holding register; a write in the load cycle is kept while the load takes the old contents.
  always_ff @(posedge FX_IFCLK) begin
    if (RST) begin
      hold_full <= 1'b0;
      hold_data <= 8'h00;
    end else if (tx_write) begin
      hold_full <= 1'b1;
      hold_data <= tx_data;
    end else if (tx_load) begin
      hold_full <= 1'b0;
    end
  end

  // Transaction datapath: latching config, shifting bytes in/out, counting completed bytes.
  always_ff @(posedge FX_IFCLK) begin
    if (RST) begin
      mode_q      <= M_SPI;
      edge_cnt    <= 3'd0;
      rx_shift    <= 8'h00;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      tx_shift    <= 8'h00;
      io_out      <= 4'b0000;
      tx_underrun <= 1'b0;
      byte_count  <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (state_q == S_IDLE && cs_fall) begin
        mode_q      <= (cfg_mode == 2'b11) ? M_SPI : cfg_mode;
        edge_cnt    <= 3'd0;
        byte_count  <= '0;
        tx_underrun <= 1'b0;
        io_out      <= 4'b0000;
      end else if (state_q == S_RX && !cs_s && sck_rise) begin
        rx_shift <= rx_next;
        if (last_edge) begin
          rx_data    <= rx_next;
          rx_valid   <= 1'b1;
          byte_count <= byte_count + COUNT_W'(1);
          edge_cnt   <= 3'd0;
        end else begin
          edge_cnt <= edge_cnt + 3'd1;
        end
      end else if (state_q == S_TX && !cs_s) begin
        if (sck_fall) begin
          if (edge_cnt == 3'd0) begin
            io_out   <= lane_bits(mode_q, load_byte);
            tx_shift <= shift_out(mode_q, load_byte);
            if (!hold_full) tx_underrun <= 1'b1;
          end else begin
            io_out   <= lane_bits(mode_q, tx_shift);
            tx_shift <= shift_out(mode_q, tx_shift);
          end
        end
        if (sck_rise) begin
          if (last_edge) begin
            byte_count <= byte_count + COUNT_W'(1);
            edge_cnt   <= 3'd0;
          end else begin
            edge_cnt <= edge_cnt + 3'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_qspi_target.sv
// tb/tb_qspi_target.sv - randomized self-checking bench for qspi_target (honours QSPI_TARGET_ECHO_EN)
module tb_qspi_target;

  localparam int SYNC = 2;
  localparam int CW   = 4;
  localparam int HALF = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cs;
  logic          sck;
  logic [3:0]    io_in;
  logic [3:0]    io_out;
  logic [3:0]    io_oe;
  logic [1:0]    cfg_mode;
  logic          cfg_dir;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          tx_underrun;
  logic [CW-1:0] byte_count;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] send_q[$];
  logic [7:0] got_q[$];
  logic [7:0] rx_log[$];
  logic [7:0] feed_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] last_rx;
  int         oe_err;
  int         busy_low;
  logic [CW-1:0] bc_at_start;
  logic       uf_at_start;

  qspi_target #(.SYNC_STAGES(SYNC), .COUNT_W(CW)) dut (
    .FX_IFCLK(clk), .RST(rst), .SPI_CS(cs), .SPI_CLK(sck),
    .io_in(io_in), .io_out(io_out), .io_oe(io_oe),
    .cfg_mode(cfg_mode), .cfg_dir(cfg_dir),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_underrun(tx_underrun), .byte_count(byte_count), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rx_valid) rx_log.push_back(rx_data);

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int lane_w(input logic [1:0] m);
    return (m == 2'b10) ? 4 : (m == 2'b01) ? 2 : 1;
  endfunction

  function automatic logic [3:0] oe_mask(input logic [1:0] m, input logic d);
    if (!d) return 4'h0;
    return (m == 2'b10) ? 4'hF : (m == 2'b01) ? 4'h3 : 4'h2;
  endfunction

  function automatic logic [7:0] fill_val();
`ifdef QSPI_TARGET_ECHO_EN
    return last_rx;
`else
    return 8'hFF;
`endif
  endfunction

  // Offer every byte of feed_q through the valid/ready handshake.
  task automatic feed_all();
    int guard = 0;
    while (feed_q.size() > 0 && guard < 20000) begin
      @(negedge clk);
      guard++;
      if (tx_ready) begin
        tx_data  = feed_q.pop_front();
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    end
    if (feed_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL feeder_timeout left=%0d required=0", feed_q.size());
      feed_q.delete();
    end
  endtask

  // Bus master: n full bytes plus tail_edges edges of a partial byte; returns right after CS rises.
  task automatic run_txn(input logic [1:0] mode, input logic dir, input int n, input int tail_edges);
    int w, epb, nb;
    logic [7:0] ob, ib, tmp;
    logic [3:0] em;
    w = lane_w(mode);
    epb = 8 / w;
    nb = n + ((tail_edges > 0) ? 1 : 0);
    em = oe_mask(mode, dir);
    got_q.delete();
    rx_log.delete();
    oe_err = 0;
    busy_low = 0;
    cfg_mode = mode;
    cfg_dir = dir;
    @(negedge clk);
    cs = 1'b0;
    wait_cyc(HALF);
    bc_at_start = byte_count;
    uf_at_start = tx_underrun;
    cfg_mode = 2'($urandom);
    cfg_dir = 1'($urandom);
    for (int b = 0; b < nb; b++) begin
      ob = (b < send_q.size()) ? send_q[b] : 8'($urandom);
      ib = 8'h00;
      for (int e = 0; e < epb; e++) begin
        if (b == n && e == tail_edges) break;
        sck = 1'b0;
        tmp = ob << (e * w);
        if (!dir) begin
          case (w)
            4:       io_in = tmp[7:4];
            2:       io_in = {2'($urandom), tmp[7:6]};
            default: io_in = {3'($urandom), tmp[7]};
          endcase
        end
        wait_cyc(HALF);
        sck = 1'b1;
        if (dir) begin
          case (w)
            4:       ib = {ib[3:0], io_out};
            2:       ib = {ib[5:0], io_out[1:0]};
            default: ib = {ib[6:0], io_out[1]};
          endcase
        end
        if (io_oe !== em) oe_err++;
        if (busy !== 1'b1) busy_low++;
        wait_cyc(HALF);
      end
      if (b < n) got_q.push_back(ib);
    end
    cs = 1'b1;
    io_in = 4'h0;
  endtask

  task automatic settle();
    wait_cyc(HALF + SYNC + 4);
  endtask

  task automatic check_rx(input string name, input int n);
    settle();
    checks++;
    if (rx_log.size() !== send_q.size()) begin
      errors++;
      $display("FAIL %s_pulses got=%0d required=%0d", name, rx_log.size(), send_q.size());
    end
    for (int i = 0; i < send_q.size() && i < rx_log.size(); i++) begin
      checks++;
      if (rx_log[i] !== send_q[i]) begin
        errors++;
        $display("FAIL %s_byte%0d got=%02h required=%02h", name, i, rx_log[i], send_q[i]);
      end
    end
    checks++;
    if (byte_count !== CW'(n)) begin
      errors++;
      $display("FAIL %s_count got=%0d required=%0d", name, byte_count, CW'(n));
    end
    checks++;
    if (oe_err != 0 || busy_low != 0) begin
      errors++;
      $display("FAIL %s_oe_busy oe_bad=%0d busy_low=%0d required=0,0", name, oe_err, busy_low);
    end
    if (n > 0) last_rx = send_q[n-1];
  endtask

  task automatic check_tx(input string name, input int n, input logic uf_exp);
    settle();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s_byte%0d got=%02h required=%02h", name, i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (tx_underrun !== uf_exp || uf_at_start !== 1'b0) begin
      errors++;
      $display("FAIL %s_underrun got=%b start=%b required=%b,0", name, tx_underrun, uf_at_start, uf_exp);
    end
    checks++;
    if (byte_count !== CW'(n) || oe_err != 0 || rx_log.size() != 0) begin
      errors++;
      $display("FAIL %s_count_oe count=%0d oe_bad=%0d rx=%0d required=%0d,0,0",
               name, byte_count, oe_err, rx_log.size(), CW'(n));
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready got=%b required=1", name, tx_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cs = 1'b1; sck = 1'b1; io_in = 4'h0;
    cfg_mode = 2'b00; cfg_dir = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
    wait_cyc(3);
    checks++;
    if ({io_out, io_oe, rx_data, rx_valid, tx_ready, tx_underrun, byte_count, busy} !==
        {4'h0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0, {CW{1'b0}}, 1'b0}) begin
      errors++;
      $display("FAIL reset_values io_out=%h oe=%h rx=%h v=%b rdy=%b uf=%b cnt=%0d busy=%b required=0,0,00,0,1,0,0,0",
               io_out, io_oe, rx_data, rx_valid, tx_ready, tx_underrun, byte_count, busy);
    end
    rst = 1'b0;
    last_rx = 8'h00;
    wait_cyc(SYNC + 4);
  endtask

  task automatic test_spi_rx();
    send_q = '{8'hA5, 8'h3C};
    run_txn(2'b00, 1'b0, 2, 0);
    check_rx("spi_rx", 2);
  endtask

  task automatic test_random_rx();
    int n;
    logic [1:0] m;
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 4);
      m = 2'($urandom);
      send_q.delete();
      for (int i = 0; i < n; i++) send_q.push_back(8'($urandom));
      run_txn(m, 1'b0, n, 0);
      check_rx($sformatf("rand_rx%0d_m%0d", t, m), n);
    end
  endtask

  task automatic test_wrap();
    send_q.delete();
    for (int i = 0; i < 17; i++) send_q.push_back(8'($urandom));
    run_txn(2'b00, 1'b0, 17, 0);
    check_rx("wrap", 17);
  endtask

  task automatic test_dpi_underrun();
    send_q.delete();
    feed_q = '{8'h5A};
    feed_all();
    exp_q = '{8'h5A, fill_val(), fill_val()};
    run_txn(2'b01, 1'b1, 3, 0);
    check_tx("dpi_underrun", 3, 1'b1);
  endtask

  task automatic test_qpi_tx();
    send_q.delete();
    feed_q = '{8'h12};
    feed_all();
    feed_q = '{8'h34};
    exp_q = '{8'h12, 8'h34};
    fork
      run_txn(2'b10, 1'b1, 2, 0);
      feed_all();
    join
    check_tx("qpi_tx", 2, 1'b0);
  endtask

  task automatic test_random_tx();
    int n, k;
    logic [1:0] m;
    logic [7:0] d;
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 4);
      k = $urandom_range(0, n);
      m = 2'($urandom);
      send_q.delete();
      exp_q.delete();
      feed_q.delete();
      for (int i = 0; i < n; i++) begin
        d = 8'($urandom);
        exp_q.push_back((i < k) ? d : fill_val());
        if (i < k) feed_q.push_back(d);
      end
      if (k > 0) begin
        d = feed_q.pop_front();
        exp_q[0] = d;
        tx_data = d;
        @(negedge clk);
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
      fork
        run_txn(m, 1'b1, n, 0);
        feed_all();
      join
      check_tx($sformatf("rand_tx%0d_m%0d_k%0d", t, m, k), n, (k < n));
    end
  endtask

  task automatic test_abort();
    send_q = '{8'($urandom), 8'($urandom)};
    run_txn(2'b00, 1'b0, 2, 5);
    repeat (SYNC + 2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy got=%b required=0", busy);
    end
    check_rx("abort", 2);
    send_q = '{8'($urandom)};
    run_txn(2'b01, 1'b0, 1, 0);
    checks++;
    if (bc_at_start !== '0) begin
      errors++;
      $display("FAIL abort_count_cleared got=%0d required=0", bc_at_start);
    end
    check_rx("after_abort", 1);
  endtask

  task automatic test_reset_mid();
    logic ok_oe;
    feed_q = '{8'($urandom)};
    feed_all();
    rx_log.delete();
    cfg_mode = 2'b10;
    cfg_dir = 1'b1;
    @(negedge clk);
    cs = 1'b0;
    wait_cyc(HALF);
    for (int e = 0; e < 3; e++) begin
      sck = ~sck;
      wait_cyc(HALF);
    end
    checks++;
    if (io_oe !== 4'hF) begin
      errors++;
      $display("FAIL mid_oe_before got=%h required=f", io_oe);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (io_oe !== 4'h0) begin
      errors++;
      $display("FAIL mid_oe_after_reset got=%h required=0", io_oe);
    end
    @(negedge clk);
    rst = 1'b0;
    last_rx = 8'h00;
    ok_oe = 1'b1;
    for (int e = 0; e < 5; e++) begin
      sck = ~sck;
      wait_cyc(HALF);
      if (io_oe !== 4'h0 || busy !== 1'b0) ok_oe = 1'b0;
    end
    cs = 1'b1;
    settle();
    checks++;
    if (!ok_oe || rx_log.size() != 0 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_ignored ok=%b rx=%0d rdy=%b required=1,0,1", ok_oe, rx_log.size(), tx_ready);
    end
    send_q = '{8'($urandom), 8'($urandom)};
    run_txn(2'b10, 1'b0, 2, 0);
    check_rx("post_reset_rx", 2);
    send_q.delete();
    exp_q = '{fill_val()};
    run_txn(2'b00, 1'b1, 1, 0);
    check_tx("post_reset_tx", 1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_spi_rx();
    test_wrap();
    test_dpi_underrun();
    test_qpi_tx();
    test_random_rx();
    test_random_tx();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout reached required=finish");
    $fatal(1);
  end

endmodule
